// File: rtl/divider32.sv
// divider32: sequential signed integer divider for the ALU multdiv path.
// A restoring shift-subtract loop produces one quotient bit per clock on the
// operand magnitudes; the sign is restored when the result is registered.
// Optional feature: define DIVIDER32_REMAINDER_EN to add the data_remainder port.

module divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef DIVIDER32_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int               CntW      = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCount = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0]  CountOne  = CntW'(1);
  localparam logic [WIDTH-1:0] MostNeg   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Zero      = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Iteration state
  state_e           state_q;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic             signQ_q;
  logic             exc_q;

  // Registered outputs
  logic [WIDTH-1:0] result_q;
  logic             exception_q;
  logic             rdy_q;

`ifdef DIVIDER32_REMAINDER_EN
  logic             signR_q;
  logic [WIDTH-1:0] remainder_q;
  logic [WIDTH-1:0] remOut_d;
`endif

  // Combinational helpers
  logic [WIDTH-1:0] absA_d;
  logic [WIDTH-1:0] absB_d;
  logic             divZero_d;
  logic             overflow_d;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] remStep_d;
  logic [WIDTH-1:0] quoStep_d;
  logic [WIDTH-1:0] quoOut_d;

  // Operand magnitudes, exception detection and one restoring step of the loop.
  always_comb begin
    absA_d     = data_operandA[WIDTH-1] ? (Zero - data_operandA) : data_operandA;
    absB_d     = data_operandB[WIDTH-1] ? (Zero - data_operandB) : data_operandB;
    divZero_d  = (data_operandB == Zero);
    overflow_d = (data_operandA == MostNeg) && (data_operandB == {WIDTH{1'b1}});

    // {R,Q} shifted left by one; the remainder needs one extra bit for the trial.
    shifted_d  = {rem_q, quo_q[WIDTH-1]};
    trial_d    = shifted_d - {1'b0, divisor_q};

    if (!trial_d[WIDTH]) begin
      remStep_d = trial_d[WIDTH-1:0];
    end else begin
      remStep_d = shifted_d[WIDTH-1:0];
    end
    quoStep_d  = {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};

    quoOut_d   = signQ_q ? (Zero - quo_q) : quo_q;
`ifdef DIVIDER32_REMAINDER_EN
    remOut_d   = signR_q ? (Zero - rem_q) : rem_q;
`endif
  end

  // Control FSM plus datapath: a start pulse in any state wins over the current
  // operation; the DONE edge still publishes its result even if a start arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      signQ_q     <= 1'b0;
      exc_q       <= 1'b0;
      result_q    <= '0;
      exception_q <= 1'b0;
      rdy_q       <= 1'b0;
`ifdef DIVIDER32_REMAINDER_EN
      signR_q     <= 1'b0;
      remainder_q <= '0;
`endif
    end else begin
      rdy_q <= 1'b0;

      case (state_q)
        RUN: begin
          rem_q   <= remStep_d;
          quo_q   <= quoStep_d;
          count_q <= count_q + CountOne;
          if (count_q == LastCount) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          result_q    <= quoOut_d;
          exception_q <= exc_q;
          rdy_q       <= 1'b1;
`ifdef DIVIDER32_REMAINDER_EN
          remainder_q <= remOut_d;
`endif
          state_q     <= IDLE;
        end
        default: begin
        end
      endcase

      if (ctrl_DIV) begin
        divisor_q <= absB_d;
        count_q   <= '0;
        if (divZero_d) begin
          // Exception results are preloaded unsigned so DONE needs no special case.
          state_q <= DONE;
          exc_q   <= 1'b1;
          quo_q   <= Zero;
          rem_q   <= data_operandA;
          signQ_q <= 1'b0;
`ifdef DIVIDER32_REMAINDER_EN
          signR_q <= 1'b0;
`endif
        end else if (overflow_d) begin
          state_q <= DONE;
          exc_q   <= 1'b1;
          quo_q   <= MostNeg;
          rem_q   <= Zero;
          signQ_q <= 1'b0;
`ifdef DIVIDER32_REMAINDER_EN
          signR_q <= 1'b0;
`endif
        end else begin
          state_q <= RUN;
          exc_q   <= 1'b0;
          quo_q   <= absA_d;
          rem_q   <= Zero;
          signQ_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
`ifdef DIVIDER32_REMAINDER_EN
          signR_q <= data_operandA[WIDTH-1];
`endif
        end
      end
    end
  end

  assign data_result    = result_q;
  assign data_exception = exception_q;
  assign data_resultRDY = rdy_q;
`ifdef DIVIDER32_REMAINDER_EN
  assign data_remainder = remainder_q;
`endif

endmodule
